dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares the single-port, word-organised data memory between two requesters: port 0 is the core load/store path and port 1 is the debug/DMA path.
- Each requester uses a valid/ready request channel and a one-cycle response pulse.
- The block sequences every access, including read-modify-write for sub-word stores using byte strobes.
- It bounds-checks addresses and sits between the requesters and the data memory, which has a combinational read and a synchronous write.

Parameters:
- ADDR_WORDS, 1024: number of 32-bit words in the memory. Word index address[31:2] >= ADDR_WORDS is out of range.
- RR_ENABLE, 1: 1 = round-robin arbitration; 0 = fixed priority, port 0 wins.

Ports:
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-high
- req_valid  input  2  per-port request valid
- req_ready  output  2  per-port request accept
- req_write  input  2  per-port; 1 = store, 0 = load
- req_addr0 / req_addr1  input  32  byte address
- req_wdata0 / req_wdata1  input  32  store data, byte lanes aligned to the word
- req_wstrb0 / req_wstrb1  input  4  store byte enables; bit i enables byte lane i (bits [8i+7:8i])
- resp_valid  output  2  per-port one-cycle response pulse
- resp_rdata  output  32  load data; valid only while a resp_valid bit is high
- resp_err  output  1  out-of-range flag, qualified by resp_valid
- mem_address  output  32  to memory; bits [1:0] are always 0
- mem_read  output  1  memory read enable
- mem_write  output  1  memory write enable
- mem_write_data  output  32  memory write data
- mem_read_data  input  32  memory read data (combinational)

Behaviour:
- Reset values:
  - state = IDLE
  - all outputs 0
  - last_grant = 1, so port 0 wins the first tie
- States: IDLE, ACCESS, MERGE, RESP. One transaction is in flight at a time.
- IDLE:
  - req_ready is asserted only here, combinationally, for the selected port only.
  - Selection:
    - only one port valid: grant that port.
    - both valid, RR_ENABLE=1: grant the port != last_grant.
    - both valid, RR_ENABLE=0: grant port 0.
  - On handshake (valid & ready): latch write, addr, wdata, wstrb and grant; update last_grant; go to ACCESS.
  - No valid: stay in IDLE.
- ACCESS:
  - mem_address = {addr[31:2], 2'b00}.
  - Out of range: no mem_read or mem_write; set err; go to RESP.
  - Load: mem_read=1; register mem_read_data into resp_rdata; go to RESP.
  - Store with wstrb=4'b1111: mem_write=1, mem_write_data=wdata; go to RESP.
  - Store with wstrb=4'b0000: no memory activity; go to RESP.
  - Partial store: mem_read=1; register merged word into a merge register (lane i = wdata lane if wstrb[i], else mem_read_data lane); go to MERGE.
- MERGE: mem_write=1, mem_write_data = merged word; go to RESP.
- RESP:
  - resp_valid[grant]=1 for exactly one cycle; resp_err = err.
  - resp_rdata = 0 for stores and for errors.
  - Go to IDLE. The next request can be accepted in the following cycle.
- Latency, counted from the handshake cycle N:
  - load, full store, or error: resp_valid at N+2
  - partial store: resp_valid at N+3
  - back-to-back throughput: one transaction per 3 (or 4) cycles
- Address bits [1:0] are ignored; no misalignment fault is raised.
- mem_read and mem_write are never high in the same cycle.
- mem_write is asserted only in ACCESS (full store) or MERGE.
- Requesters must hold their request stable while valid and not ready. The latched copy makes changes after the handshake irrelevant.
- Reset mid-transaction: return to IDLE and clear all outputs. No mem_write occurs in the cycle rst is sampled high. A pending response is dropped.
- A request arriving while busy waits; ready stays 0 until the block is back in IDLE.

Test Plan:
- Port 0 stores 0xDEADBEEF at 0x40 with wstrb=F, then loads 0x40 -> store resp_valid[0] at N+2 with err=0; load resp_valid[0] at N+2 with resp_rdata=0xDEADBEEF.
- Word 0x40 = 0xDEADBEEF; port 1 stores wdata=0x00AA0000 at 0x42 with wstrb=0100, then loads 0x40 -> resp at N+3; mem_read then mem_write on consecutive cycles; load returns 0xDEAABEEF.
- Both ports hold valid continuously, RR_ENABLE=1 -> grants alternate 0,1,0,1; each port receives exactly one resp_valid per grant.
- Same stimulus with RR_ENABLE=0 -> port 0 granted every time; port 1 never ready while port 0 is valid.
- Load at byte address 0x1000 with ADDR_WORDS=1024 -> no mem_read or mem_write; resp_err=1; resp_rdata=0 at N+2.
- rst asserted during MERGE -> no mem_write that cycle; memory word unchanged; next cycle state=IDLE and all outputs 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port word memory (combinational read, synchronous write).
// Each access goes through ACCESS, and sub-word stores take an extra MERGE cycle for read-modify-write.
module dmem_arbiter #(
    parameter int unsigned ADDR_WORDS = 1024,
    parameter bit          RR_ENABLE  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [1:0]  req_write,
    input  logic [31:0] req_addr0,
    input  logic [31:0] req_addr1,
    input  logic [31:0] req_wdata0,
    input  logic [31:0] req_wdata1,
    input  logic [3:0]  req_wstrb0,
    input  logic [3:0]  req_wstrb1,
    output logic [1:0]  resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [1:0] {IDLE, ACCESS, MERGE, RESP} state_t;

    state_t      state, state_nxt;
    logic        last_grant, grant, sel, handshake;
    logic        err;
    logic        lat_write;
    logic [31:0] lat_addr, lat_wdata;
    logic [3:0]  lat_wstrb;
    logic [31:0] rdata_q, merge_q;
    logic        out_of_range, full_store, null_store;
    logic        unused_addr_bits;

    function automatic logic [31:0] merge_word(input logic [31:0] wdata,
                                               input logic [31:0] old,
                                               input logic [3:0]  wstrb);
        logic [31:0] w;
        w = old;
        for (int i = 0; i < 4; i++) begin
            if (wstrb[i]) w[8*i +: 8] = wdata[8*i +: 8];
        end
        return w;
    endfunction

    // Byte offset is ignored: accesses are always whole-word aligned.
    assign unused_addr_bits = ^lat_addr[1:0];
    assign out_of_range     = {2'b00, lat_addr[31:2]} >= ADDR_WORDS;
    assign full_store       = lat_wstrb == 4'b1111;
    assign null_store       = lat_wstrb == 4'b0000;

    always_comb begin
        sel = 1'b0;
        case (req_valid)
            2'b10:   sel = 1'b1;
            2'b11:   sel = RR_ENABLE ? ~last_grant : 1'b0;
            default: sel = 1'b0;
        endcase
    end

    assign handshake = (state == IDLE) && !rst && req_valid[sel];

    // Outputs are suppressed while rst is high so an interrupted MERGE never writes.
    always_comb begin
        state_nxt      = state;
        req_ready      = 2'b00;
        resp_valid     = 2'b00;
        resp_rdata     = 32'h0;
        resp_err       = 1'b0;
        mem_address    = 32'h0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_write_data = 32'h0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    req_ready[sel] = req_valid[sel];
                    if (handshake) state_nxt = ACCESS;
                end
                ACCESS: begin
                    mem_address = {lat_addr[31:2], 2'b00};
                    state_nxt   = RESP;
                    if (!out_of_range) begin
                        if (!lat_write) begin
                            mem_read = 1'b1;
                        end else if (full_store) begin
                            mem_write      = 1'b1;
                            mem_write_data = lat_wdata;
                        end else if (!null_store) begin
                            mem_read  = 1'b1;
                            state_nxt = MERGE;
                        end
                    end
                end
                MERGE: begin
                    mem_address    = {lat_addr[31:2], 2'b00};
                    mem_write      = 1'b1;
                    mem_write_data = merge_q;
                    state_nxt      = RESP;
                end
                RESP: begin
                    resp_valid[grant] = 1'b1;
                    resp_err          = err;
                    resp_rdata        = rdata_q;
                    state_nxt         = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant      <= 1'b0;
            err        <= 1'b0;
        end else begin
            state <= state_nxt;
            if (handshake) begin
                last_grant <= sel;
                grant      <= sel;
            end
            if (state == ACCESS) err <= out_of_range;
        end
    end

    // Request capture and access results; data path carries no reset.
    always_ff @(posedge clk) begin
        if (handshake) begin
            lat_write <= req_write[sel];
            lat_addr  <= sel ? req_addr1  : req_addr0;
            lat_wdata <= sel ? req_wdata1 : req_wdata0;
            lat_wstrb <= sel ? req_wstrb1 : req_wstrb0;
        end
        if (state == ACCESS) begin
            rdata_q <= (!out_of_range && !lat_write) ? mem_read_data : 32'h0;
            merge_q <= merge_word(lat_wdata, mem_read_data, lat_wstrb);
        end
    end

endmodule
